data_bus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the shared peripheral data bus: `data_bus_data`, `data_bus_addr` and `data_bus_mode`, where mode 00 is idle, 01 is read and 10 is write. It sits between the bus masters (core load/store unit on master 0, auxiliary master such as a debug or DMA unit on master 1) and all memory-mapped peripherals, such as the LED port at 0x4F00. It grants the bus round-robin and runs each granted request as exactly one bus cycle. It drives write data onto the shared tri-state data lines, captures read data, and returns it with a one-cycle acknowledge.

---
 rtl/data_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_data_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter and single-cycle sequencer for the
// shared peripheral data bus (mode 00 idle, 01 read, 10 write).
module data_bus_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [1:0]  m0_mode,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ack,
   input  logic        m1_req,
   input  logic [1:0]  m1_mode,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ack,
   inout  wire  [31:0] data_bus_data,
   output logic [31:0] data_bus_addr,
   output logic [1:0]  data_bus_mode,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ACK
   } state_t;

   localparam logic [1:0] MODE_IDLE  = 2'b00;
   localparam logic [1:0] MODE_READ  = 2'b01;
   localparam logic [1:0] MODE_WRITE = 2'b10;

   state_t      state;
   state_t      state_n;
   logic        last_grant;
   logic        last_grant_n;
   logic        sel;
   logic        sel_n;
   logic [1:0]  cap_mode;
   logic [1:0]  cap_mode_n;
   logic [31:0] wdata_q;
   logic [31:0] wdata_n;
   logic        drive;
   logic        drive_n;
   logic [31:0] addr_n;
   logic [1:0]  mode_n;
   logic        ack0_n;
   logic        ack1_n;
   logic [31:0] rdata0_n;
   logic [31:0] rdata1_n;
   logic        busy_n;

   logic        any_req;
   logic        pick;
   logic [1:0]  req_mode;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] rd_value;

   // Under contention the master that did not win last time goes next.
   assign any_req   = m0_req | m1_req;
   assign pick      = (m0_req & m1_req) ? ~last_grant : m1_req;
   assign req_mode  = pick ? m1_mode  : m0_mode;
   assign req_addr  = pick ? m1_addr  : m0_addr;
   assign req_wdata = pick ? m1_wdata : m0_wdata;

   // Null modes complete with zero read data.
   assign rd_value = (cap_mode == MODE_READ) ? data_bus_data : 32'h0;

   assign data_bus_data = drive ? wdata_q : 32'bz;

   always_comb begin
      state_n      = state;
      last_grant_n = last_grant;
      sel_n        = sel;
      cap_mode_n   = cap_mode;
      wdata_n      = wdata_q;
      addr_n       = 32'h0;
      mode_n       = MODE_IDLE;
      drive_n      = 1'b0;
      ack0_n       = 1'b0;
      ack1_n       = 1'b0;
      rdata0_n     = m0_rdata;
      rdata1_n     = m1_rdata;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               state_n      = ACCESS;
               sel_n        = pick;
               last_grant_n = pick;
               cap_mode_n   = req_mode;
               wdata_n      = req_wdata;
               addr_n       = req_addr;
               if ((req_mode == MODE_READ) ||
                   (req_mode == MODE_WRITE))
                  mode_n = req_mode;
               drive_n = (req_mode == MODE_WRITE);
            end
         end
         ACCESS: begin
            state_n = ACK;
            if (sel)
               ack1_n = 1'b1;
            else
               ack0_n = 1'b1;
            if (cap_mode != MODE_WRITE) begin
               if (sel)
                  rdata1_n = rd_value;
               else
                  rdata0_n = rd_value;
            end
         end
         ACK: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         sel           <= 1'b0;
         cap_mode      <= MODE_IDLE;
         wdata_q       <= 32'h0;
         drive         <= 1'b0;
         data_bus_addr <= 32'h0;
         data_bus_mode <= MODE_IDLE;
         m0_ack        <= 1'b0;
         m1_ack        <= 1'b0;
         m0_rdata      <= 32'h0;
         m1_rdata      <= 32'h0;
         busy          <= 1'b0;
      end else begin
         state         <= state_n;
         last_grant    <= last_grant_n;
         sel           <= sel_n;
         cap_mode      <= cap_mode_n;
         wdata_q       <= wdata_n;
         drive         <= drive_n;
         data_bus_addr <= addr_n;
         data_bus_mode <= mode_n;
         m0_ack        <= ack0_n;
         m1_ack        <= ack1_n;
         m0_rdata      <= rdata0_n;
         m1_rdata      <= rdata1_n;
         busy          <= busy_n;
      end
   end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Randomized bench for data_bus_arbiter with a transaction-level model,
// an LED peripheral at 0x4F00 and a read-back pattern elsewhere.
module tb_data_bus_arbiter;

   localparam logic [31:0] LED = 32'h4F00;
   localparam logic [31:0] KEY = 32'h5A5A0F0F;

   typedef struct packed {
      logic [1:0]  mode;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        m0_req = 1'b0;
   logic [1:0]  m0_mode = 2'b00;
   logic [31:0] m0_addr = 32'h0;
   logic [31:0] m0_wdata = 32'h0;
   logic [31:0] m0_rdata;
   logic        m0_ack;
   logic        m1_req = 1'b0;
   logic [1:0]  m1_mode = 2'b00;
   logic [31:0] m1_addr = 32'h0;
   logic [31:0] m1_wdata = 32'h0;
   logic [31:0] m1_rdata;
   logic        m1_ack;
   wire  [31:0] data_bus_data;
   logic [31:0] data_bus_addr;
   logic [1:0]  data_bus_mode;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_bus_arbiter dut (
      .clk(clk),
      .reset(reset),
      .m0_req(m0_req),
      .m0_mode(m0_mode),
      .m0_addr(m0_addr),
      .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata),
      .m0_ack(m0_ack),
      .m1_req(m1_req),
      .m1_mode(m1_mode),
      .m1_addr(m1_addr),
      .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata),
      .m1_ack(m1_ack),
      .data_bus_data(data_bus_data),
      .data_bus_addr(data_bus_addr),
      .data_bus_mode(data_bus_mode),
      .busy(busy)
   );

   // Peripheral: LED register at 0x4F00, address-derived data elsewhere.
   logic [31:0] led = 32'h0;
   assign data_bus_data = (data_bus_mode == 2'b01) ?
      ((data_bus_addr == LED) ? led : (data_bus_addr ^ KEY)) : 32'bz;

   always @(posedge clk)
      if (data_bus_mode == 2'b10 && data_bus_addr == LED)
         led <= data_bus_data;

   // Transaction-level model: a granted request owns the bus for three
   // edges (bus cycle, ack cycle, idle cycle) before the next is sampled.
   logic        act = 1'b0;
   int          age = 0;
   logic        w = 1'b0;
   logic        lg = 1'b1;
   txn_t        cur = '0;
   logic [31:0] mled = 32'h0;
   logic [31:0] mrd0 = 32'h0;
   logic [31:0] mrd1 = 32'h0;
   int          glog[$];

   function automatic logic pick(input logic r0, input logic r1,
                                 input logic l);
      return (r0 && r1) ? !l : r1;
   endfunction

   function automatic logic [31:0] result(input txn_t t,
                                          input logic [31:0] m);
      if (t.mode == 2'b01)
         return (t.addr == LED) ? m : (t.addr ^ KEY);
      return 32'h0;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         act  <= 1'b0;
         age  <= 0;
         lg   <= 1'b1;
         mrd0 <= 32'h0;
         mrd1 <= 32'h0;
      end else if (act && age == 0) begin
         age <= 1;
         if (cur.mode == 2'b10) begin
            if (cur.addr == LED)
               mled <= cur.wdata;
         end else if (w) begin
            mrd1 <= result(cur, mled);
         end else begin
            mrd0 <= result(cur, mled);
         end
      end else if (act && age == 1) begin
         age <= 2;
      end else begin
         act <= 1'b0;
         if (m0_req || m1_req) begin
            act <= 1'b1;
            age <= 0;
            w   <= pick(m0_req, m1_req, lg);
            lg  <= pick(m0_req, m1_req, lg);
            cur <= pick(m0_req, m1_req, lg) ?
                   {m1_mode, m1_addr, m1_wdata} :
                   {m0_mode, m0_addr, m0_wdata};
            glog.push_back(int'(pick(m0_req, m1_req, lg)));
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      automatic logic bp = act && age == 0;
      automatic logic ap = act && age == 1;
      automatic logic rw = (cur.mode == 2'b01) || (cur.mode == 2'b10);
      chk("bus_mode", data_bus_mode, (bp && rw) ? cur.mode : 2'b00);
      chk("bus_addr", data_bus_addr, bp ? cur.addr : 32'h0);
      chk("drive", dut.drive, bp && cur.mode == 2'b10);
      if (bp && cur.mode == 2'b10)
         chk("bus_data", data_bus_data, cur.wdata);
      chk("m0_ack", m0_ack, ap && !w);
      chk("m1_ack", m1_ack, ap && w);
      chk("busy", busy, act && age < 2);
      chk("m0_rdata", m0_rdata, mrd0);
      chk("m1_rdata", m1_rdata, mrd1);
   end

   // Masters: hold req with the queue head until the model's ack.
   txn_t q0[$];
   txn_t q1[$];
   logic on0 = 1'b0;
   logic on1 = 1'b0;
   bit   nogap = 1'b1;

   task automatic step();
      @(negedge clk);
      #1;
      if (act && age == 1 && !w && on0) begin
         void'(q0.pop_front());
         on0 = 1'b0;
      end
      if (act && age == 1 && w && on1) begin
         void'(q1.pop_front());
         on1 = 1'b0;
      end
      if (!on0 && q0.size() > 0 && (nogap || $urandom_range(1) == 0))
         on0 = 1'b1;
      if (!on1 && q1.size() > 0 && (nogap || $urandom_range(1) == 0))
         on1 = 1'b1;
      m0_req = on0;
      m1_req = on1;
      if (on0) begin
         m0_mode  = q0[0].mode;
         m0_addr  = q0[0].addr;
         m0_wdata = q0[0].wdata;
      end else begin
         m0_mode  = 2'($urandom);
         m0_addr  = $urandom;
         m0_wdata = $urandom;
      end
      if (on1) begin
         m1_mode  = q1[0].mode;
         m1_addr  = q1[0].addr;
         m1_wdata = q1[0].wdata;
      end else begin
         m1_mode  = 2'($urandom);
         m1_addr  = $urandom;
         m1_wdata = $urandom;
      end
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || act) && n < maxc) begin
         step();
         n++;
      end
      checks++;
      if (n >= maxc) begin
         errors++;
         $display("FAIL drain_timeout got %0d cycles want <%0d", n, maxc);
      end
   endtask

   function automatic txn_t rnd_txn();
      txn_t t;
      t.mode  = 2'($urandom);
      t.addr  = ($urandom_range(2) == 0) ? LED : ($urandom & 32'hFFFF);
      t.wdata = $urandom;
      return t;
   endfunction

   initial begin
      int base;
      int n;
      q0.push_back('{2'b10, LED, 32'h000000A5});
      q1.push_back('{2'b01, LED, 32'h0});
      repeat (3) step();
      chk("rst_mode", data_bus_mode, 2'b00);
      chk("rst_addr", data_bus_addr, 32'h0);
      chk("rst_drive", dut.drive, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ack", {m0_ack, m1_ack}, 2'b00);
      reset = 1'b1;
      drain(50);
      chk("grant_count", glog.size(), 2);
      chk("first_grant", glog[0], 0);
      chk("second_grant", glog[1], 1);
      chk("led_write", led, 32'hA5);
      chk("m1_readback", m1_rdata, 32'hA5);

      base = glog.size();
      for (int i = 0; i < 4; i++) begin
         q0.push_back('{2'b01, 32'h1000 + 32'(i * 4), 32'h0});
         q1.push_back('{2'b10, 32'h2000 + 32'(i), 32'(i)});
      end
      drain(100);
      for (int i = 0; i < 8; i++)
         chk("contend_order", glog[base + i], 32'(i % 2));

      q0.push_back('{2'b11, LED, 32'h33});
      drain(20);
      chk("null_led", led, 32'hA5);
      chk("null_rdata", m0_rdata, 32'h0);

      q0.push_back('{2'b10, LED, 32'h77});
      n = 0;
      do begin
         step();
         n++;
      end while (!(act && age == 0) && n < 20);
      chk("mid_reached", 32'(n < 20), 32'h1);
      reset = 1'b0;
      #1;
      chk("mid_mode", data_bus_mode, 2'b00);
      chk("mid_drive", dut.drive, 1'b0);
      chk("mid_busy", busy, 1'b0);
      q0.delete();
      q1.delete();
      on0 = 1'b0;
      on1 = 1'b0;
      repeat (2) step();
      reset = 1'b1;
      base = glog.size();
      q0.push_back('{2'b01, LED, 32'h0});
      q1.push_back('{2'b01, LED, 32'h0});
      drain(50);
      chk("post_rst_grant", glog[base], 0);
      chk("mid_led", led, 32'hA5);
      chk("post_rst_rdata", m0_rdata, 32'hA5);

      nogap = 1'b0;
      for (int i = 0; i < 160; i++) begin
         if ($urandom_range(1) == 0)
            q0.push_back(rnd_txn());
         else
            q1.push_back(rnd_txn());
      end
      drain(4000);
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
